// File: rtl/wb_stage_ctrl_pkg.sv
// Shared constants for the write-back stage: byte-lane enable patterns
// and the word-address helper used for LL/SC link matching.
package wb_stage_ctrl_pkg;

   localparam int BE_BITS = 4;

   localparam logic [BE_BITS-1:0] BE_WORD    = 4'b1111;
   localparam logic [BE_BITS-1:0] BE_HALF_LO = 4'b0011;
   localparam logic [BE_BITS-1:0] BE_HALF_HI = 4'b1100;
   localparam logic [BE_BITS-1:0] BE_B0      = 4'b0001;
   localparam logic [BE_BITS-1:0] BE_B1      = 4'b0010;
   localparam logic [BE_BITS-1:0] BE_B2      = 4'b0100;
   localparam logic [BE_BITS-1:0] BE_B3      = 4'b1000;

   // Links are tracked per 32-bit word, so the two byte-offset bits are dropped.
   localparam int WORD_LSB = 2;

   function automatic int word_bits(input int bits);
      return bits - WORD_LSB;
   endfunction

endpackage

// File: rtl/wb_stage_ctrl_if.sv
// Pipeline-side bundle into the write-back stage: the MEM/WB register
// fields, the S4 SC probe, the external link kill and the SC verdict back to S4.
interface wb_stage_ctrl_if
   import wb_stage_ctrl_pkg::*;
#(
   parameter int BITS      = 32,
   parameter int ADDR_LEFT = 4
);

   logic                 sel_mem_s5;
   logic                 rw_s5;
   logic [ADDR_LEFT:0]   waddr_s5;
   logic                 load_link_s5;
   logic                 check_link_s5;
   logic                 mem_rw_s5;
   logic                 halt_s5;
   logic [BE_BITS-1:0]   byte_en_s5;
   logic [BITS-1:0]      alu_out_s5;
   logic [BITS-1:0]      mem_rdata_s5;
   logic                 check_link_s4;
   logic [BITS-1:0]      alu_out_s4;
   logic                 link_inval;
   logic                 sc_ok_s4;

   modport master (
      output sel_mem_s5, rw_s5, waddr_s5, load_link_s5, check_link_s5,
             mem_rw_s5, halt_s5, byte_en_s5, alu_out_s5, mem_rdata_s5,
             check_link_s4, alu_out_s4, link_inval,
      input  sc_ok_s4
   );

   modport slave (
      input  sel_mem_s5, rw_s5, waddr_s5, load_link_s5, check_link_s5,
             mem_rw_s5, halt_s5, byte_en_s5, alu_out_s5, mem_rdata_s5,
             check_link_s4, alu_out_s4, link_inval,
      output sc_ok_s4
   );

endinterface

// File: rtl/wb_stage_ctrl_load_align.sv
// Load alignment: picks the addressed byte or halfword out of the raw
// memory word and right-aligns it with zero extension.
module wb_stage_ctrl_load_align
   import wb_stage_ctrl_pkg::*;
#(
   parameter int BITS = 32
) (
   input  logic [BITS-1:0]    mem_rdata,
   input  logic [BE_BITS-1:0] byte_en,
   output logic [BITS-1:0]    aligned
);

   // Unrecognised lane patterns fall back to the full word.
   always_comb begin
      aligned = mem_rdata;
      case (byte_en)
         BE_WORD:    aligned = mem_rdata;
         BE_HALF_LO: aligned = {{(BITS-16){1'b0}}, mem_rdata[15:0]};
         BE_HALF_HI: aligned = {{(BITS-16){1'b0}}, mem_rdata[31:16]};
         BE_B0:      aligned = {{(BITS-8){1'b0}}, mem_rdata[7:0]};
         BE_B1:      aligned = {{(BITS-8){1'b0}}, mem_rdata[15:8]};
         BE_B2:      aligned = {{(BITS-8){1'b0}}, mem_rdata[23:16]};
         BE_B3:      aligned = {{(BITS-8){1'b0}}, mem_rdata[31:24]};
         default:    aligned = mem_rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage_ctrl.sv
// Write-back stage control: register-file write port, LL/SC link state,
// the S4 store-conditional verdict, sticky halt and saturating retire counter.
module wb_stage_ctrl
   import wb_stage_ctrl_pkg::*;
#(
   parameter int BITS      = 32,
   parameter int REG_WORDS = 32,
   parameter int ADDR_LEFT = $clog2(REG_WORDS)-1,
   parameter int CNT_BITS  = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   wb_stage_ctrl_if.slave              bus,
   output logic                        rf_we,
   output logic [ADDR_LEFT:0]          rf_waddr,
   output logic [BITS-1:0]             rf_wdata,
   output logic                        link_valid,
   output logic [word_bits(BITS)-1:0]  link_addr,
   output logic                        halted,
   output logic [CNT_BITS-1:0]         retire_cnt
);

   localparam int LBITS = word_bits(BITS);

   logic [LBITS-1:0] word_s5;
   logic [LBITS-1:0] word_s4;
   logic [LBITS-1:0] link_addr_nxt;
   logic             link_valid_nxt;
   logic             sc_ok_q;
   logic             retire;
   logic [BITS-1:0]  aligned;

   assign word_s5 = bus.alu_out_s5[BITS-1:WORD_LSB];
   assign word_s4 = bus.alu_out_s4[BITS-1:WORD_LSB];

   wb_stage_ctrl_load_align #(.BITS(BITS)) u_align (
      .mem_rdata (bus.mem_rdata_s5),
      .byte_en   (bus.byte_en_s5),
      .aligned   (aligned)
   );

   // Link next state: an external kill beats everything, then LL, then SC, then a hitting store.
   always_comb begin
      link_valid_nxt = link_valid;
      link_addr_nxt  = link_addr;
      if (bus.link_inval) begin
         link_valid_nxt = 1'b0;
      end else if (bus.load_link_s5 && !halted) begin
         link_valid_nxt = 1'b1;
         link_addr_nxt  = word_s5;
      end else if (bus.check_link_s5) begin
         link_valid_nxt = 1'b0;
      end else if (bus.mem_rw_s5 && link_valid && (word_s5 == link_addr)) begin
         link_valid_nxt = 1'b0;
      end
   end

   // The S4 SC looks at next-state link so an LL or killing store in S5 is seen this cycle.
   always_comb begin
      bus.sc_ok_s4 = bus.check_link_s4 && link_valid_nxt &&
                     (word_s4 == link_addr_nxt) && !halted;
   end

   // Write port is taken straight from the S5 register; SC results win over loads over ALU.
   always_comb begin
      rf_waddr = bus.waddr_s5;
      rf_we    = bus.rw_s5 && (|bus.waddr_s5) && !halted && !rst;
      if (bus.check_link_s5) begin
         rf_wdata = {{(BITS-1){1'b0}}, sc_ok_q};
      end else if (bus.sel_mem_s5) begin
         rf_wdata = aligned;
      end else begin
         rf_wdata = bus.alu_out_s5;
      end
   end

   assign retire = (bus.rw_s5 || bus.mem_rw_s5 || bus.halt_s5) && !halted;

   // Stage state: link, SC verdict pipeline, sticky halt and the saturating counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         link_valid <= 1'b0;
         link_addr  <= '0;
         sc_ok_q    <= 1'b0;
         halted     <= 1'b0;
         retire_cnt <= '0;
      end else begin
         link_valid <= link_valid_nxt;
         link_addr  <= link_addr_nxt;
         sc_ok_q    <= bus.sc_ok_s4;
         if (bus.halt_s5) begin
            halted <= 1'b1;
         end
         if (retire && (retire_cnt != '1)) begin
            retire_cnt <= retire_cnt + CNT_BITS'(1);
         end
      end
   end

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Bench for wb_stage_ctrl: directed vector table, hand-written halt and
// reset sequences, then random traffic checked against a reference model.
module tb_wb_stage_ctrl;

   localparam int BITS = 32;
   localparam int ADDR_LEFT = 4;
   localparam int CNT_BITS = 4;
   localparam int CNT_MAX = 15;

   typedef struct packed {
      logic        ll;
      logic        sc5;
      logic        mem_rw;
      logic        halt;
      logic        rw;
      logic        sel_mem;
      logic [4:0]  waddr;
      logic [3:0]  be;
      logic [31:0] alu5;
      logic [31:0] rdata;
      logic        sc4;
      logic [31:0] alu4;
      logic        inval;
   } stim_t;

   typedef struct packed {
      stim_t       s;
      logic        sc_ok;
      logic        we;
      logic [31:0] wdata;
      logic        link;
      logic [3:0]  cnt;
   } vec_t;

   logic clk;
   logic rst;
   logic                 rf_we;
   logic [ADDR_LEFT:0]   rf_waddr;
   logic [BITS-1:0]      rf_wdata;
   logic                 link_valid;
   logic [BITS-3:0]      link_addr;
   logic                 halted;
   logic [CNT_BITS-1:0]  retire_cnt;

   wb_stage_ctrl_if #(.BITS(BITS), .ADDR_LEFT(ADDR_LEFT)) bus ();

   wb_stage_ctrl #(.BITS(BITS), .REG_WORDS(32), .ADDR_LEFT(ADDR_LEFT), .CNT_BITS(CNT_BITS)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .link_valid (link_valid),
      .link_addr  (link_addr),
      .halted     (halted),
      .retire_cnt (retire_cnt)
   );

   int vectors = 0;
   int miscompares = 0;

   stim_t cur;
   logic        m_lv;
   logic [29:0] m_la;
   logic        m_scq;
   logic        m_halted;
   int          m_cnt;

   vec_t tbl [28];

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic stim_t mkStim(logic ll, logic sc5, logic mem_rw, logic halt, logic rw,
                                    logic sel_mem, logic [4:0] waddr, logic [3:0] be,
                                    logic [31:0] alu5, logic [31:0] rdata, logic sc4,
                                    logic [31:0] alu4, logic inval);
      stim_t s;
      s.ll = ll; s.sc5 = sc5; s.mem_rw = mem_rw; s.halt = halt; s.rw = rw;
      s.sel_mem = sel_mem; s.waddr = waddr; s.be = be; s.alu5 = alu5; s.rdata = rdata;
      s.sc4 = sc4; s.alu4 = alu4; s.inval = inval;
      return s;
   endfunction

   function automatic vec_t mkVec(stim_t s, logic sc_ok, logic we, logic [31:0] wdata,
                                  logic link, logic [3:0] cnt);
      vec_t v;
      v.s = s; v.sc_ok = sc_ok; v.we = we; v.wdata = wdata; v.link = link; v.cnt = cnt;
      return v;
   endfunction

   function automatic logic [31:0] alignRef(logic [31:0] w, logic [3:0] be);
      int lane;
      lane = 0;
      case (be)
         4'b1111: return w;
         4'b0011: return w & 32'h0000_FFFF;
         4'b1100: return w >> 16;
         4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
            for (int i = 0; i < 4; i++) if (be[i]) lane = i;
            return (w >> (8 * lane)) & 32'h0000_00FF;
         end
         default: return w;
      endcase
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic resetModel();
      m_lv = 1'b0; m_la = '0; m_scq = 1'b0; m_halted = 1'b0; m_cnt = 0;
   endtask

   task automatic driveBus(input stim_t s);
      bus.load_link_s5  = s.ll;
      bus.check_link_s5 = s.sc5;
      bus.mem_rw_s5     = s.mem_rw;
      bus.halt_s5       = s.halt;
      bus.rw_s5         = s.rw;
      bus.sel_mem_s5    = s.sel_mem;
      bus.waddr_s5      = s.waddr;
      bus.byte_en_s5    = s.be;
      bus.alu_out_s5    = s.alu5;
      bus.mem_rdata_s5  = s.rdata;
      bus.check_link_s4 = s.sc4;
      bus.alu_out_s4    = s.alu4;
      bus.link_inval    = s.inval;
      cur = s;
   endtask

   task automatic applyStimulus(input stim_t s);
      @(posedge clk);
      #1;
      driveBus(s);
      #2;
   endtask

   // Compare against the reference model for the current cycle, then step the model.
   task automatic checkOutput();
      logic        nv;
      logic [29:0] na;
      logic        e_sc;
      logic        e_we;
      logic [31:0] e_wd;
      nv = m_lv;
      na = m_la;
      if (cur.inval) nv = 1'b0;
      else if (cur.ll && !m_halted) begin nv = 1'b1; na = cur.alu5[31:2]; end
      else if (cur.sc5) nv = 1'b0;
      else if (cur.mem_rw && m_lv && (cur.alu5[31:2] == m_la)) nv = 1'b0;
      e_sc = cur.sc4 && nv && (cur.alu4[31:2] == na) && !m_halted;
      e_we = cur.rw && (cur.waddr != 0) && !m_halted;
      e_wd = cur.sc5 ? {31'd0, m_scq} : (cur.sel_mem ? alignRef(cur.rdata, cur.be) : cur.alu5);
      cmp("sc_ok_s4", {31'd0, bus.sc_ok_s4}, {31'd0, e_sc});
      cmp("rf_we", {31'd0, rf_we}, {31'd0, e_we});
      cmp("rf_waddr", {27'd0, rf_waddr}, {27'd0, cur.waddr});
      cmp("rf_wdata", rf_wdata, e_wd);
      cmp("link_valid", {31'd0, link_valid}, {31'd0, m_lv});
      cmp("link_addr", {2'd0, link_addr}, {2'd0, m_la});
      cmp("halted", {31'd0, halted}, {31'd0, m_halted});
      cmp("retire_cnt", {28'd0, retire_cnt}, 32'(m_cnt));
      if ((cur.rw || cur.mem_rw || cur.halt) && !m_halted && m_cnt < CNT_MAX) m_cnt++;
      if (cur.halt) m_halted = 1'b1;
      m_lv = nv;
      m_la = na;
      m_scq = e_sc;
   endtask

   // Synchronous-looking reset pulse, with a write request held to show rf_we is gated.
   task automatic doReset();
      rst = 1'b1;
      driveBus(mkStim(0,0,0,0,1,0,5'd5,4'hF,32'h0,32'h0,0,32'h0,0));
      @(posedge clk);
      #1;
      cmp("rst_rf_we", {31'd0, rf_we}, 32'd0);
      cmp("rst_link_valid", {31'd0, link_valid}, 32'd0);
      cmp("rst_link_addr", {2'd0, link_addr}, 32'd0);
      cmp("rst_halted", {31'd0, halted}, 32'd0);
      cmp("rst_retire_cnt", {28'd0, retire_cnt}, 32'd0);
      rst = 1'b0;
      driveBus(mkStim(0,0,0,0,0,0,5'd0,4'h0,32'h0,32'h0,0,32'h0,0));
      resetModel();
   endtask

   // Reset asserted between edges must clear state without waiting for a clock.
   task automatic asyncReset();
      #1;
      bus.rw_s5 = 1'b1;
      bus.waddr_s5 = 5'd9;
      rst = 1'b1;
      #1;
      cmp("arst_rf_we", {31'd0, rf_we}, 32'd0);
      cmp("arst_link_valid", {31'd0, link_valid}, 32'd0);
      cmp("arst_halted", {31'd0, halted}, 32'd0);
      cmp("arst_retire_cnt", {28'd0, retire_cnt}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      driveBus(mkStim(0,0,0,0,0,0,5'd0,4'h0,32'h0,32'h0,0,32'h0,0));
      resetModel();
   endtask

   function automatic stim_t randStim();
      logic [31:0] pool [4];
      stim_t s;
      pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200; pool[3] = 32'h300;
      s.ll      = ($urandom_range(0, 5) == 0);
      s.sc5     = ($urandom_range(0, 5) == 0);
      s.mem_rw  = ($urandom_range(0, 3) == 0);
      s.halt    = ($urandom_range(0, 99) == 0);
      s.rw      = $urandom_range(0, 1) == 1;
      s.sel_mem = $urandom_range(0, 1) == 1;
      s.waddr   = 5'($urandom_range(0, 31));
      s.be      = 4'($urandom_range(0, 15));
      s.alu5    = pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
      s.rdata   = $urandom;
      s.sc4     = ($urandom_range(0, 3) == 0);
      s.alu4    = pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
      s.inval   = ($urandom_range(0, 11) == 0);
      return s;
   endfunction

   // Main test sequence.
   initial begin
      rst = 1'b1;
      resetModel();
      driveBus(mkStim(0,0,0,0,0,0,5'd0,4'h0,32'h0,32'h0,0,32'h0,0));

      //                    ll sc5 st hlt rw mem wa     be     alu5         rdata        sc4 alu4    inv   sc we wdata        lnk cnt
      tbl[0]  = mkVec(mkStim(1,0,0,0,1,1,5'd5,4'hF,32'h100,32'h12345678,0,32'h0,0),   0,1,32'h12345678,0,4'd0);
      tbl[1]  = mkVec(mkStim(0,0,0,0,0,0,5'd0,4'h0,32'h0,32'h0,0,32'h0,0),            0,0,32'h0,1,4'd1);
      tbl[2]  = mkVec(mkStim(0,0,0,0,0,0,5'd0,4'h0,32'h0,32'h0,1,32'h100,0),          1,0,32'h0,1,4'd1);
      tbl[3]  = mkVec(mkStim(0,1,1,0,1,0,5'd6,4'hF,32'h100,32'h0,0,32'h0,0),          0,1,32'h1,1,4'd1);
      tbl[4]  = mkVec(mkStim(0,0,0,0,0,0,5'd0,4'h0,32'h0,32'h0,0,32'h0,0),            0,0,32'h0,0,4'd2);
      tbl[5]  = mkVec(mkStim(1,0,0,0,1,1,5'd7,4'hF,32'h100,32'h0,0,32'h0,0),          0,1,32'h0,0,4'd2);
      tbl[6]  = mkVec(mkStim(0,0,1,0,0,0,5'd0,4'hF,32'h102,32'h0,0,32'h0,0),          0,0,32'h102,1,4'd3);
      tbl[7]  = mkVec(mkStim(0,0,0,0,0,0,5'd0,4'h0,32'h0,32'h0,1,32'h100,0),          0,0,32'h0,0,4'd4);
      tbl[8]  = mkVec(mkStim(0,1,1,0,1,0,5'd8,4'hF,32'h100,32'h0,0,32'h0,0),          0,1,32'h0,0,4'd4);
      tbl[9]  = mkVec(mkStim(1,0,0,0,1,1,5'd9,4'hF,32'h100,32'h0,0,32'h0,0),          0,1,32'h0,0,4'd5);
      tbl[10] = mkVec(mkStim(0,0,1,0,0,0,5'd0,4'hF,32'h104,32'h0,0,32'h0,0),          0,0,32'h104,1,4'd6);
      tbl[11] = mkVec(mkStim(0,0,0,0,0,0,5'd0,4'h0,32'h0,32'h0,1,32'h100,0),          1,0,32'h0,1,4'd7);
      tbl[12] = mkVec(mkStim(0,1,1,0,1,0,5'd10,4'hF,32'h100,32'h0,0,32'h0,0),         0,1,32'h1,1,4'd7);
      tbl[13] = mkVec(mkStim(0,0,0,0,0,0,5'd0,4'h0,32'h0,32'h0,0,32'h0,0),            0,0,32'h0,0,4'd8);
      tbl[14] = mkVec(mkStim(1,0,0,0,1,1,5'd11,4'hF,32'h200,32'hCAFEF00D,1,32'h200,0),1,1,32'hCAFEF00D,0,4'd8);
      tbl[15] = mkVec(mkStim(0,1,1,0,1,0,5'd12,4'hF,32'h200,32'h0,0,32'h0,0),         0,1,32'h1,1,4'd9);
      tbl[16] = mkVec(mkStim(0,0,0,0,0,0,5'd0,4'h0,32'h0,32'h0,0,32'h0,0),            0,0,32'h0,0,4'd10);
      tbl[17] = mkVec(mkStim(1,0,0,0,1,1,5'd13,4'hF,32'h200,32'h0,0,32'h0,0),         0,1,32'h0,0,4'd10);
      tbl[18] = mkVec(mkStim(0,0,1,0,0,0,5'd0,4'hF,32'h200,32'h0,1,32'h200,0),        0,0,32'h200,1,4'd11);
      tbl[19] = mkVec(mkStim(0,0,0,0,0,0,5'd0,4'h0,32'h0,32'h0,0,32'h0,0),            0,0,32'h0,0,4'd12);
      tbl[20] = mkVec(mkStim(0,0,0,0,1,1,5'd1,4'b0100,32'h0,32'hA1B2C3D4,0,32'h0,0),  0,1,32'hB2,0,4'd12);
      tbl[21] = mkVec(mkStim(0,0,0,0,1,1,5'd1,4'b1100,32'h0,32'hA1B2C3D4,0,32'h0,0),  0,1,32'hA1B2,0,4'd13);
      tbl[22] = mkVec(mkStim(0,0,0,0,1,1,5'd1,4'b1111,32'h0,32'hA1B2C3D4,0,32'h0,0),  0,1,32'hA1B2C3D4,0,4'd14);
      tbl[23] = mkVec(mkStim(0,0,0,0,1,1,5'd0,4'b0001,32'h0,32'hA1B2C3D4,0,32'h0,0),  0,0,32'hD4,0,4'd15);
      tbl[24] = mkVec(mkStim(0,0,0,0,1,1,5'd2,4'b1000,32'h0,32'hA1B2C3D4,0,32'h0,0),  0,1,32'hA1,0,4'd15);
      tbl[25] = mkVec(mkStim(0,0,0,0,0,0,5'd0,4'h0,32'h0,32'h0,0,32'h0,0),            0,0,32'h0,0,4'd15);
      tbl[26] = mkVec(mkStim(1,0,0,0,1,1,5'd3,4'hF,32'h300,32'h0,1,32'h300,1),        0,1,32'h0,0,4'd15);
      tbl[27] = mkVec(mkStim(0,0,0,0,0,0,5'd0,4'h0,32'h0,32'h0,0,32'h0,0),            0,0,32'h0,0,4'd15);

      @(posedge clk);
      #1;
      doReset();

      for (int i = 0; i < 28; i++) begin
         applyStimulus(tbl[i].s);
         cmp($sformatf("tbl%0d_sc_ok", i), {31'd0, bus.sc_ok_s4}, {31'd0, tbl[i].sc_ok});
         cmp($sformatf("tbl%0d_we", i), {31'd0, rf_we}, {31'd0, tbl[i].we});
         cmp($sformatf("tbl%0d_wdata", i), rf_wdata, tbl[i].wdata);
         cmp($sformatf("tbl%0d_link", i), {31'd0, link_valid}, {31'd0, tbl[i].link});
         cmp($sformatf("tbl%0d_cnt", i), {28'd0, retire_cnt}, {28'd0, tbl[i].cnt});
         checkOutput();
      end

      // Halt is counted, then freezes writes, links and the counter.
      doReset();
      applyStimulus(mkStim(0,0,0,0,1,0,5'd4,4'hF,32'h55,32'h0,0,32'h0,0));
      checkOutput();
      applyStimulus(mkStim(0,0,0,1,0,0,5'd0,4'h0,32'h0,32'h0,0,32'h0,0));
      cmp("halt_cnt_before", {28'd0, retire_cnt}, 32'd1);
      checkOutput();
      applyStimulus(mkStim(0,0,0,0,1,0,5'd4,4'hF,32'h66,32'h0,0,32'h0,0));
      cmp("halt_rf_we", {31'd0, rf_we}, 32'd0);
      cmp("halt_flag", {31'd0, halted}, 32'd1);
      cmp("halt_cnt_counted", {28'd0, retire_cnt}, 32'd2);
      checkOutput();
      applyStimulus(mkStim(1,0,0,0,1,1,5'd4,4'hF,32'h100,32'h0,0,32'h0,0));
      checkOutput();
      applyStimulus(mkStim(0,0,0,0,0,0,5'd0,4'h0,32'h0,32'h0,1,32'h100,0));
      cmp("halt_no_link", {31'd0, link_valid}, 32'd0);
      cmp("halt_cnt_frozen", {28'd0, retire_cnt}, 32'd2);
      checkOutput();
      asyncReset();

      // LL done and SC pending when reset hits: the SC must fail afterwards.
      applyStimulus(mkStim(1,0,0,0,1,1,5'd5,4'hF,32'h100,32'h0,0,32'h0,0));
      checkOutput();
      applyStimulus(mkStim(0,0,0,0,0,0,5'd0,4'h0,32'h0,32'h0,1,32'h100,0));
      cmp("pend_sc_ok", {31'd0, bus.sc_ok_s4}, 32'd1);
      checkOutput();
      asyncReset();
      applyStimulus(mkStim(0,1,1,0,1,0,5'd6,4'hF,32'h100,32'h0,0,32'h0,0));
      cmp("pend_sc_wdata", rf_wdata, 32'd0);
      cmp("pend_sc_we", {31'd0, rf_we}, 32'd1);
      checkOutput();

      // Random traffic against the reference model, with occasional resets.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 49) == 0) begin
            @(posedge clk);
            #1;
            doReset();
         end
         applyStimulus(randStim());
         checkOutput();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
